// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: fills a 44-word round-key buffer one word per clock
// and serves any round key combinationally to the downstream decryption core.
module aes_key_schedule #(
    parameter  int NR = 10,
    localparam int NW = 4 * (NR + 1)
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic [127:0] KEY,
    output logic         BUSY,
    output logic         DONE,
    input  logic [3:0]   RK_IDX,
    output logic [127:0] RK_OUT
);

    typedef enum logic [1:0] {IDLE, EXPAND, FINISHED} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t      state, state_next;
    logic [31:0] w [NW];
    logic [5:0]  cnt;
    logic [7:0]  rcon;
    logic        accept;
    logic [31:0] prev_word, sub_rot, temp, new_word;

    assign accept = START && (state != EXPAND);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            IDLE: begin
                if (START) state_next = EXPAND;
            end
            EXPAND: begin
                BUSY = 1'b1;
                if (cnt == 6'(NW - 1)) state_next = FINISHED;
            end
            FINISHED: begin
                DONE = 1'b1;
                if (START) state_next = EXPAND;
            end
            default: state_next = IDLE;
        endcase
    end

    // Word i depends on w[i-1] and w[i-4]; every fourth word takes the RotWord/SubWord/rcon path.
    always_comb begin
        prev_word = w[cnt - 6'd1];
        sub_rot   = {SBOX[prev_word[23:16]], SBOX[prev_word[15:8]],
                     SBOX[prev_word[7:0]],   SBOX[prev_word[31:24]]};
        temp      = (cnt[1:0] == 2'b00) ? (sub_rot ^ {rcon, 24'h0}) : prev_word;
        new_word  = w[cnt - 6'd4] ^ temp;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int j = 0; j < NW; j++) w[j] <= '0;
            cnt  <= '0;
            rcon <= 8'h01;
        end else if (accept) begin
            w[0] <= KEY[127:96];
            w[1] <= KEY[95:64];
            w[2] <= KEY[63:32];
            w[3] <= KEY[31:0];
            for (int j = 4; j < NW; j++) w[j] <= '0;
            cnt  <= 6'd4;
            rcon <= 8'h01;
        end else if (state == EXPAND) begin
            w[cnt] <= new_word;
            cnt    <= cnt + 6'd1;
            if (cnt[1:0] == 2'b00)
                rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end

    always_comb begin
        RK_OUT = '0;
        if (RK_IDX <= 4'(NR))
            RK_OUT = {w[{RK_IDX, 2'b00}], w[{RK_IDX, 2'b01}],
                      w[{RK_IDX, 2'b10}], w[{RK_IDX, 2'b11}]};
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: a GF(2^8)-derived AES key-expansion model predicts
// BUSY/DONE/RK_OUT every cycle, with FIPS-197 literals pinning the model.
module tb_aes_key_schedule;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         START = 1'b0;
    logic [127:0] KEY = '0;
    logic [3:0]   RK_IDX = '0;
    logic         BUSY, DONE;
    logic [127:0] RK_OUT;

    localparam logic [127:0] A1_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_RK1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam int MS_IDLE = 0, MS_EXPAND = 1, MS_FIN = 2;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] sbox_t [256];

    int           m_state = MS_IDLE;
    int           m_valid = 0;
    logic [127:0] m_key = '0;

    aes_key_schedule dut (
        .CLK(CLK), .RESET(RESET), .START(START), .KEY(KEY),
        .BUSY(BUSY), .DONE(DONE), .RK_IDX(RK_IDX), .RK_OUT(RK_OUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box built from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Round key idx of key k as seen when only the first 'valid' words have been produced.
    function automatic logic [127:0] model_rk(input logic [127:0] k, input int idx, input int valid);
        logic [31:0] ww [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        logic [127:0] r = '0;
        if (idx > 10) return '0;
        ww[0] = k[127:96]; ww[1] = k[95:64]; ww[2] = k[63:32]; ww[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = ww[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            ww[i] = ww[i-4] ^ t;
        end
        for (int j = 0; j < 4; j++)
            r = (r << 32) | ((4*idx + j < valid) ? 128'(ww[4*idx + j]) : 128'h0);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_state <= MS_IDLE;
            m_valid <= 0;
        end else if (m_state != MS_EXPAND && START) begin
            m_key   <= KEY;
            m_state <= MS_EXPAND;
            m_valid <= 4;
        end else if (m_state == MS_EXPAND) begin
            m_valid <= m_valid + 1;
            if (m_valid == 43) m_state <= MS_FIN;
        end
    end

    always @(negedge CLK) begin
        check("busy", 128'(BUSY), 128'(m_state == MS_EXPAND));
        check("done", 128'(DONE), 128'(m_state == MS_FIN));
        check("rk_out", RK_OUT, model_rk(m_key, int'(RK_IDX), m_valid));
    end

    task automatic start_key(input logic [127:0] k);
        @(posedge CLK); #1;
        KEY = k;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n_edges = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) begin
                n_edges = n;
                break;
            end
        end
        check(name, 128'(n_edges), 128'd40);
    endtask

    task automatic read_rk(input string name, input logic [3:0] idx, input logic [127:0] exp);
        RK_IDX = idx;
        #1;
        check(name, RK_OUT, exp);
    endtask

    initial begin
        build_sbox();
        check("model_a1_rk1", model_rk(A1_KEY, 1, 44), A1_RK1);
        check("model_a1_rk10", model_rk(A1_KEY, 10, 44), A1_RK10);
        check("model_zero_rk1", model_rk('0, 1, 44), ZERO_RK1);
        check("model_zero_rk10", model_rk('0, 10, 44), ZERO_RK10);

        #2;
        check("reset_busy", 128'(BUSY), 128'd0);
        check("reset_done", 128'(DONE), 128'd0);
        read_rk("reset_rk0", 4'd0, '0);
        #9 RESET = 1'b1;

        start_key(A1_KEY);
        wait_done("a1_latency");
        read_rk("a1_rk0", 4'd0, A1_KEY);
        read_rk("a1_rk1", 4'd1, A1_RK1);
        read_rk("a1_rk10", 4'd10, A1_RK10);
        read_rk("oor_rk11", 4'd11, '0);
        check("oor_done", 128'(DONE), 128'd1);
        read_rk("oor_rk15", 4'd15, '0);
        check("oor_busy", 128'(BUSY), 128'd0);

        start_key('0);
        check("restart_done_low", 128'(DONE), 128'd0);
        check("restart_busy_high", 128'(BUSY), 128'd1);
        wait_done("zero_latency");
        read_rk("zero_rk1", 4'd1, ZERO_RK1);
        read_rk("zero_rk10", 4'd10, ZERO_RK10);

        // Start-while-busy: a second START at edge 10 plus a churning KEY must not disturb the run.
        begin
            int n_edges = 0;
            start_key(A1_KEY);
            for (int n = 2; n <= 100; n++) begin
                @(posedge CLK); #1;
                if (DONE === 1'b1) begin
                    n_edges = n - 1;
                    break;
                end
                START = (n == 10);
                KEY = (n == 10) ? '0 : {$urandom, $urandom, $urandom, $urandom};
            end
            START = 1'b0;
            check("busy_ignore_latency", 128'(n_edges), 128'd40);
            read_rk("busy_ignore_rk1", 4'd1, A1_RK1);
            read_rk("busy_ignore_rk10", 4'd10, A1_RK10);
        end

        start_key(A1_KEY);
        repeat (20) @(posedge CLK);
        #3 RESET = 1'b0;
        #1;
        check("async_busy", 128'(BUSY), 128'd0);
        check("async_done", 128'(DONE), 128'd0);
        for (int i = 0; i < 16; i++) read_rk("async_rk", 4'(i), '0);
        #7 RESET = 1'b1;
        start_key(A1_KEY);
        wait_done("post_reset_latency");
        read_rk("post_reset_rk10", 4'd10, A1_RK10);

        for (int it = 0; it < 6; it++) begin
            start_key({$urandom, $urandom, $urandom, $urandom});
            for (int c = 0; c < 45; c++) begin
                @(posedge CLK); #1;
                RK_IDX = 4'($urandom_range(0, 15));
                START = ($urandom_range(0, 9) == 0);
                KEY = {$urandom, $urandom, $urandom, $urandom};
            end
            START = 1'b0;
        end

        START = 1'b1;
        for (int c = 0; c < 130; c++) begin
            @(posedge CLK); #1;
            RK_IDX = 4'($urandom_range(0, 15));
            KEY = {$urandom, $urandom, $urandom, $urandom};
        end
        START = 1'b0;
        repeat (45) begin
            @(posedge CLK); #1;
            RK_IDX = 4'($urandom_range(0, 15));
        end

        @(posedge CLK); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
